loop_stack_unit: RTL and testbench
==================================

# loop_stack_unit

Hardware loop controller for the processor's LOOP instruction family, generalised to nested loops. It holds a stack of up to DEPTH loop counters. A loop-setup instruction pushes a counter, and each loop-end instruction decrements the top counter and decides, by loop type and zero flag, whether to branch back or fall through. Results are registered and returned one cycle later to the fetch/PC-select stage.

## Interface
- WIDTH, 16: counter and address width.
- DEPTH, 4: maximum loop nesting (stack entries), ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  loop setup: push count_i as new top.
- count_i  in  WIDTH  initial iteration count for push.
- check  in  1  loop-end evaluation on top entry.
- type  in  2  00 LOOP_NORMAL, 01 LOOP_E, 10 LOOP_NE, 11 reserved.
- zf  in  1  zero flag sampled with check.
- addr  in  WIDTH  branch-back target.
- pc_i  in  WIDTH  fall-through PC.
- valid_o  out  1  one-cycle pulse, check result present.
- taken_o  out  1  branch back taken.
- pc_o  out  WIDTH  selected next PC (addr if taken, else pc_i).
- count_o  out  WIDTH  top-of-stack counter after update (0 if empty).
- depth_o  out  clog2(DEPTH+1)  current number of entries.
- err_ovf  out  1  sticky: push while full.
- err_unf  out  1  sticky: check while empty.
- err_type  out  1  sticky: check with type 11.

## Operation
- Push: count_i written to entry[depth], depth+1. count_i = 0 is loaded as 1 (body runs once). Push while depth = DEPTH: dropped, err_ovf set, stack unchanged.
- Check on non-empty stack, with top counter c:
  - LOOP_NORMAL: cont = (c != 1).
  - LOOP_E: cont = (c != 1) && zf.
  - LOOP_NE: cont = (c != 1) && !zf.
  - type 11: cont = 0, err_type set.
- cont = 1: top ← c − 1 (WIDTH-bit), taken_o = 1, pc_o = addr.
- cont = 0: entry popped (depth−1), taken_o = 0, pc_o = pc_i.
- Check while empty: err_unf set, taken_o = 0, pc_o = pc_i, valid_o still pulses.
- Simultaneous push and check: the check is applied to the current top first, then the push.
  - If the check popped, the new entry occupies the freed slot (depth unchanged).
  - Otherwise it goes above the updated top (depth+1, overflow rules apply against the post-check depth).
  - Push-with-check on an empty stack: err_unf set, the push still succeeds.
- Counter arithmetic is unsigned, modulo 2^WIDTH. Value 1 ends the loop, so the counter never decrements below 1 in normal use.
- Error flags are sticky until rst. They do not block further operation.

## Timing
- Reset (rst high at a clk edge): depth 0, all entries 0, valid_o 0, taken_o 0, pc_o 0, count_o 0, all err flags 0. rst has priority over push/check in the same cycle. It clears an in-flight result: valid_o is 0 in the following cycle.
- Latency: check sampled at edge N; valid_o/taken_o/pc_o valid after edge N and held until edge N+1. valid_o is high for exactly one cycle per check.
- pc_o/taken_o hold their last values while valid_o = 0.
- depth_o/count_o reflect the stack state after the edge's updates.
- Back-to-back checks every cycle are supported: each check sees the stack as updated by the previous edge. There is no stall and no ready signal.
- addr, pc_i, type and zf are sampled only when check = 1.

## Test plan
- Reset then push 3, type 00, check ×3 with addr=0x0040, pc_i=0x0050:
  - taken_o 1,1,0; pc_o 0x0040,0x0040,0x0050; count_o 2,1,0; depth_o ends 0.
- LOOP_E:
  - Push 5, check with zf=1 → taken, count_o 4.
  - Check with zf=0 → not taken, pop, depth 0.
  - Repeat with LOOP_NE and inverted zf for the same result.
- Nesting: DEPTH=4, push 2 then 3.
  - Check ×3 on inner: taken, taken, pop.
  - Then count_o = 2 and depth_o = 1.
  - A 5th push after filling all 4 entries sets err_ovf, depth_o stays 4.
- Empty and reserved cases:
  - Check on empty stack → valid_o 1, taken_o 0, pc_o = pc_i, err_unf 1.
  - Check with type 11 on depth 1 → pop, err_type 1.
- Simultaneous push(7) + check on top=1 → old entry popped, new top 7, depth unchanged. Same with top=4 → top 3 below, new top 7, depth+1.
- Boundary values:
  - push count_i=0 → count_o 1; next check not taken.
  - rst asserted the cycle after a check → valid_o 0, all outputs and flags cleared.

Source files
------------

// File: rtl/loop_stack_unit_if.sv
// Bus bundle for the loop stack unit: loop setup/check requests in, registered results and status out.
interface loop_stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             i_push;
  logic [WIDTH-1:0] i_count;
  logic             i_check;
  logic [1:0]       i_type;
  logic             i_zf;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_pc;
  logic             o_valid;
  logic             o_taken;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] o_count;
  logic [DW-1:0]    o_depth;
  logic             o_err_ovf;
  logic             o_err_unf;
  logic             o_err_type;

  modport master (
    output i_push, i_count, i_check, i_type, i_zf, i_addr, i_pc,
    input  o_valid, o_taken, o_pc, o_count, o_depth, o_err_ovf, o_err_unf, o_err_type
  );

  modport slave (
    input  i_push, i_count, i_check, i_type, i_zf, i_addr, i_pc,
    output o_valid, o_taken, o_pc, o_count, o_depth, o_err_ovf, o_err_unf, o_err_type
  );
endinterface

// File: rtl/loop_stack_unit.sv
// Nested hardware-loop controller: a stack of loop counters with push on setup
// and decrement/pop on loop-end checks; branch decision is registered for fetch.
module loop_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  loop_stack_unit_if.slave bus
);
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_valid;
  logic             r_taken;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_count;
  logic             r_err_ovf;
  logic             r_err_unf;
  logic             r_err_type;

  logic [WIDTH-1:0] w_stack_nx [DEPTH];
  logic [DW-1:0]    w_depth_nx;
  logic [IDX_W-1:0] w_top_idx;
  logic [WIDTH-1:0] w_top;
  logic             w_cont;
  logic             w_ovf;
  logic             w_unf;
  logic             w_type_err;
  logic [WIDTH-1:0] w_count_nx;

  // Check is resolved against the current top first; a same-cycle push then
  // lands on the post-check depth, reusing a slot the check may have freed.
  always_comb begin
    w_stack_nx = r_stack;
    w_depth_nx = r_depth;
    w_top_idx  = IDX_W'(r_depth - DW'(1));
    w_top      = r_stack[w_top_idx];
    w_cont     = 1'b0;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_type_err = 1'b0;
    w_count_nx = '0;

    if (bus.i_check) begin
      if (r_depth == '0) begin
        w_unf = 1'b1;
      end else begin
        case (bus.i_type)
          2'b00:   w_cont = (w_top != WIDTH'(1));
          2'b01:   w_cont = (w_top != WIDTH'(1)) && bus.i_zf;
          2'b10:   w_cont = (w_top != WIDTH'(1)) && !bus.i_zf;
          default: w_type_err = 1'b1;
        endcase
        if (w_cont) w_stack_nx[w_top_idx] = w_top - WIDTH'(1);
        else        w_depth_nx = r_depth - DW'(1);
      end
    end

    if (bus.i_push) begin
      if (w_depth_nx == DW'(DEPTH)) begin
        w_ovf = 1'b1;
      end else begin
        w_stack_nx[IDX_W'(w_depth_nx)] = (bus.i_count == '0) ? WIDTH'(1) : bus.i_count;
        w_depth_nx = w_depth_nx + DW'(1);
      end
    end

    if (w_depth_nx != '0) w_count_nx = w_stack_nx[IDX_W'(w_depth_nx - DW'(1))];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_depth    <= '0;
      r_valid    <= 1'b0;
      r_taken    <= 1'b0;
      r_pc       <= '0;
      r_count    <= '0;
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_type <= 1'b0;
    end else begin
      r_stack    <= w_stack_nx;
      r_depth    <= w_depth_nx;
      r_count    <= w_count_nx;
      r_valid    <= bus.i_check;
      r_err_ovf  <= r_err_ovf  | w_ovf;
      r_err_unf  <= r_err_unf  | w_unf;
      r_err_type <= r_err_type | w_type_err;
      if (bus.i_check) begin
        r_taken <= w_cont;
        r_pc    <= w_cont ? bus.i_addr : bus.i_pc;
      end
    end
  end

  assign bus.o_valid    = r_valid;
  assign bus.o_taken    = r_taken;
  assign bus.o_pc       = r_pc;
  assign bus.o_count    = r_count;
  assign bus.o_depth    = r_depth;
  assign bus.o_err_ovf  = r_err_ovf;
  assign bus.o_err_unf  = r_err_unf;
  assign bus.o_err_type = r_err_type;
endmodule

// File: tb/tb_loop_stack_unit.sv
// Directed bench for loop_stack_unit with hand-computed expectations.
module tb_loop_stack_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  loop_stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  loop_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock with the given request, sampled 1ns after the edge
  task automatic op(input logic p, input logic [15:0] cnt, input logic c, input logic [1:0] t,
                    input logic z, input logic [15:0] a, input logic [15:0] pc);
    bus.i_push  = p;
    bus.i_count = cnt;
    bus.i_check = c;
    bus.i_type  = t;
    bus.i_zf    = z;
    bus.i_addr  = a;
    bus.i_pc    = pc;
    @(posedge clk);
    #1;
    bus.i_push  = 1'b0;
    bus.i_check = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic tk, input logic [15:0] pc,
                         input logic [15:0] cnt, input logic [2:0] d);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
    chk({tag, ".taken"}, 32'(bus.o_taken), 32'(tk));
    chk({tag, ".pc"},    32'(bus.o_pc),    32'(pc));
    chk({tag, ".count"}, 32'(bus.o_count), 32'(cnt));
    chk({tag, ".depth"}, 32'(bus.o_depth), 32'(d));
  endtask

  task automatic chk_err(input string tag, input logic ovf, input logic unf, input logic typ);
    chk({tag, ".ovf"},  32'(bus.o_err_ovf),  32'(ovf));
    chk({tag, ".unf"},  32'(bus.o_err_unf),  32'(unf));
    chk({tag, ".type"}, 32'(bus.o_err_type), 32'(typ));
  endtask

  initial begin
    bus.i_push = 0; bus.i_count = 0; bus.i_check = 0; bus.i_type = 0;
    bus.i_zf = 0; bus.i_addr = 0; bus.i_pc = 0;
    @(posedge clk); #1;
    do_reset();
    chk_res("reset", 0, 0, 16'h0, 16'd0, 3'd0);
    chk_err("reset", 0, 0, 0);

    // basic LOOP_NORMAL, count 3
    op(1, 16'd3, 0, 2'b00, 0, 16'h0, 16'h0);
    chk_res("n.push", 0, 0, 16'h0, 16'd3, 3'd1);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0040, 16'h0050);
    chk_res("n.c1", 1, 1, 16'h0040, 16'd2, 3'd1);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0040, 16'h0050);
    chk_res("n.c2", 1, 1, 16'h0040, 16'd1, 3'd1);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0040, 16'h0050);
    chk_res("n.c3", 1, 0, 16'h0050, 16'd0, 3'd0);
    op(0, 16'd0, 0, 2'b00, 0, 16'h1111, 16'h2222);
    chk_res("n.idle", 0, 0, 16'h0050, 16'd0, 3'd0);

    // LOOP_E then LOOP_NE with inverted zf
    op(1, 16'd5, 0, 2'b00, 0, 16'h0, 16'h0);
    op(0, 16'd0, 1, 2'b01, 1, 16'h0100, 16'h0200);
    chk_res("e.take", 1, 1, 16'h0100, 16'd4, 3'd1);
    op(0, 16'd0, 1, 2'b01, 0, 16'h0100, 16'h0200);
    chk_res("e.fall", 1, 0, 16'h0200, 16'd0, 3'd0);
    op(1, 16'd5, 0, 2'b00, 0, 16'h0, 16'h0);
    op(0, 16'd0, 1, 2'b10, 0, 16'h0300, 16'h0400);
    chk_res("ne.take", 1, 1, 16'h0300, 16'd4, 3'd1);
    op(0, 16'd0, 1, 2'b10, 1, 16'h0300, 16'h0400);
    chk_res("ne.fall", 1, 0, 16'h0400, 16'd0, 3'd0);

    // nesting and overflow
    op(1, 16'd2, 0, 2'b00, 0, 16'h0, 16'h0);
    op(1, 16'd3, 0, 2'b00, 0, 16'h0, 16'h0);
    chk_res("nest.push", 0, 0, 16'h0400, 16'd3, 3'd2);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0010, 16'h0020);
    chk_res("nest.c1", 1, 1, 16'h0010, 16'd2, 3'd2);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0010, 16'h0020);
    chk_res("nest.c2", 1, 1, 16'h0010, 16'd1, 3'd2);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0010, 16'h0020);
    chk_res("nest.c3", 1, 0, 16'h0020, 16'd2, 3'd1);
    op(1, 16'd6, 0, 2'b00, 0, 16'h0, 16'h0);
    op(1, 16'd7, 0, 2'b00, 0, 16'h0, 16'h0);
    op(1, 16'd8, 0, 2'b00, 0, 16'h0, 16'h0);
    chk_res("full", 0, 0, 16'h0020, 16'd8, 3'd4);
    chk_err("full", 0, 0, 0);
    op(1, 16'd9, 0, 2'b00, 0, 16'h0, 16'h0);
    chk_res("ovf", 0, 0, 16'h0020, 16'd8, 3'd4);
    chk_err("ovf", 1, 0, 0);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0055, 16'h0066);
    chk_res("ovf.after", 1, 1, 16'h0055, 16'd7, 3'd4);

    // empty and reserved-type cases
    do_reset();
    chk_err("rst2", 0, 0, 0);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0AAA, 16'h0123);
    chk_res("unf", 1, 0, 16'h0123, 16'd0, 3'd0);
    chk_err("unf", 0, 1, 0);
    op(1, 16'd6, 1, 2'b00, 0, 16'h0AAA, 16'h0124);
    chk_res("unf.push", 1, 0, 16'h0124, 16'd6, 3'd1);
    op(0, 16'd0, 1, 2'b11, 0, 16'h0AAA, 16'h0125);
    chk_res("type11", 1, 0, 16'h0125, 16'd0, 3'd0);
    chk_err("type11", 0, 1, 1);

    // simultaneous push + check
    do_reset();
    op(1, 16'd1, 0, 2'b00, 0, 16'h0, 16'h0);
    op(1, 16'd7, 1, 2'b00, 0, 16'h0700, 16'h0800);
    chk_res("pc.pop", 1, 0, 16'h0800, 16'd7, 3'd1);
    do_reset();
    op(1, 16'd4, 0, 2'b00, 0, 16'h0, 16'h0);
    op(1, 16'd7, 1, 2'b00, 0, 16'h0700, 16'h0800);
    chk_res("pc.take", 1, 1, 16'h0700, 16'd7, 3'd2);
    op(0, 16'd0, 1, 2'b11, 0, 16'h0700, 16'h0900);
    chk_res("pc.below", 1, 0, 16'h0900, 16'd3, 3'd1);
    chk_err("pc.below", 0, 0, 1);

    // push 0 runs once
    do_reset();
    op(1, 16'd0, 0, 2'b00, 0, 16'h0, 16'h0);
    chk_res("z.push", 0, 0, 16'h0, 16'd1, 3'd1);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0A00, 16'h0B00);
    chk_res("z.chk", 1, 0, 16'h0B00, 16'd0, 3'd0);

    // reset right after a check clears everything, including the in-flight result
    op(0, 16'd0, 1, 2'b00, 0, 16'h0A00, 16'h0B01);
    chk_err("pre.rst", 0, 1, 0);
    op(1, 16'd5, 0, 2'b00, 0, 16'h0, 16'h0);
    op(0, 16'd0, 1, 2'b00, 0, 16'h0C00, 16'h0D00);
    chk_res("pre.rst", 1, 1, 16'h0C00, 16'd4, 3'd1);
    rst = 1'b1;
    op(1, 16'd9, 1, 2'b00, 0, 16'h0C00, 16'h0D00);
    rst = 1'b0;
    chk_res("post.rst", 0, 0, 16'h0, 16'd0, 3'd0);
    chk_err("post.rst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
